pool_accum_ctrl: RTL and testbench

Window-accumulation controller for the pooling stage. It sequences a single shared `qadd` instance over a stream of fixed-point operands. For each pooling window it accumulates `POOL_SIZE` accepted beats and emits one sum, or one average, over a valid/ready output handshake. It sits between the upstream activation stream and the pooling output buffer.

---
 rtl/pool_pkg.sv | 19 +
 rtl/qadd.sv | 12 +
 rtl/pool_accum_ctrl.sv | 96 +++++++++
 tb/tb_pool_accum_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling accumulation controller: FSM states and
// an elaboration-time log2 helper.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pool_state_e;

  // Ceiling log2; exact for the power-of-two window sizes this block accepts.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/qadd.sv
// Fixed-point adder shared by the pooling datapath; wraps modulo 2^N.
module qadd #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  assign c = a + b;

endmodule

// File: rtl/pool_accum_ctrl.sv
// Window-accumulation controller: sums POOL_SIZE accepted beats through one
// shared qadd and presents the sum (or its average) on a valid/ready output.
module pool_accum_ctrl
  import pool_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int POOL_SIZE = 4,
  parameter bit AVG       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DWIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DWIDTH-1:0]   out_data,
  output logic                  busy
);

  localparam int W          = 2 * DWIDTH;
  localparam int POOL_SHIFT = clog2(POOL_SIZE);
  localparam int CNT_W      = POOL_SHIFT + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);

  if ((POOL_SIZE < 2) || (POOL_SIZE > 16) || ((POOL_SIZE & (POOL_SIZE - 1)) != 0)) begin : g_bad_pool
    $error("pool_accum_ctrl: POOL_SIZE must be a power of two in 2..16");
  end

  pool_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            acc_q, acc_d;
  logic [W-1:0]            out_data_q, out_data_d;
  logic [W-1:0]            add_a;
  logic signed [W-1:0]     add_c;
  logic                    accept;

  // First beat of a window starts from zero so no stale sum leaks through.
  assign add_a = (cnt_q == '0) ? '0 : acc_q;

  qadd #(.N(W)) u_qadd (
    .a (add_a),
    .b (in_data),
    .c (add_c)
  );

  // Handshake outputs decode registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = add_c;
          if (cnt_q == LAST_CNT) begin
            cnt_d      = '0;
            state_d    = DONE;
            out_data_d = AVG ? W'(add_c >>> POOL_SHIFT) : add_c;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pool_accum_ctrl.sv
// Scoreboard bench: a sum instance and an average instance run in lockstep on
// shared stimulus; a monitor pops expected results on each output handshake.
module tb_pool_accum_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        sum_in_ready, sum_out_valid, sum_busy;
  logic [15:0] sum_out_data;
  logic        avg_in_ready, avg_out_valid, avg_busy;
  logic [15:0] avg_out_data;

  logic [15:0] exp_sum_q[$];
  logic [15:0] exp_avg_q[$];

  int checks = 0;
  int errors = 0;

  pool_accum_ctrl #(.DWIDTH(8), .POOL_SIZE(4), .AVG(1'b0)) u_sum (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (sum_in_ready),
    .in_data   (in_data),
    .out_valid (sum_out_valid),
    .out_ready (out_ready),
    .out_data  (sum_out_data),
    .busy      (sum_busy)
  );

  pool_accum_ctrl #(.DWIDTH(8), .POOL_SIZE(4), .AVG(1'b1)) u_avg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (avg_in_ready),
    .in_data   (in_data),
    .out_valid (avg_out_valid),
    .out_ready (out_ready),
    .out_data  (avg_out_data),
    .busy      (avg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every completed output handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (sum_out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) check("sum_unexpected_output", sum_out_data, 16'hxxxx);
        else check("sum_result", sum_out_data, exp_sum_q.pop_front());
      end
      if (avg_out_valid && out_ready) begin
        if (exp_avg_q.size() == 0) check("avg_unexpected_output", avg_out_data, 16'hxxxx);
        else check("avg_result", avg_out_data, exp_avg_q.pop_front());
      end
    end
  end

  // Presents one beat and holds it until both instances accept it.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!(sum_in_ready && avg_in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 16'(n), 16'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic expect_window(input logic [15:0] s, input logic [15:0] a);
    exp_sum_q.push_back(s);
    exp_avg_q.push_back(a);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((sum_busy || avg_busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {14'd0, sum_busy, avg_busy}, 16'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, {14'd0, sum_out_valid, avg_out_valid}, 16'd0);
    check({tag, "_out_data_sum"}, sum_out_data, 16'h0000);
    check({tag, "_out_data_avg"}, avg_out_data, 16'h0000);
    check({tag, "_in_ready"}, {14'd0, sum_in_ready, avg_in_ready}, 16'h0003);
    check({tag, "_busy"}, {14'd0, sum_busy, avg_busy}, 16'd0);
  endtask

  logic [15:0] held_sum;
  logic [15:0] held_avg;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Sum/average of 0x10..0x40 on consecutive cycles.
    @(posedge clk);
    #1;
    expect_window(16'h00A0, 16'h0028);
    send(16'h0010);
    send(16'h0020);
    send(16'h0030);
    send(16'h0040);
    @(negedge clk);
    check("latency_out_valid", {14'd0, sum_out_valid, avg_out_valid}, 16'h0003);
    check("done_in_ready_low", {14'd0, sum_in_ready, avg_in_ready}, 16'h0000);
    wait_idle("idle_after_w1");

    // Negative average rounds toward -inf.
    @(posedge clk);
    #1;
    expect_window(16'hFFFA, 16'hFFFE);
    send(16'hFFFD);
    send(16'hFFFE);
    send(16'hFFFF);
    send(16'h0000);
    wait_idle("idle_after_neg");

    // Wrap without saturation, held under 5 cycles of backpressure.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expect_window(16'h8000, 16'hE000);
    send(16'h7FFF);
    send(16'h0001);
    send(16'h0000);
    send(16'h0000);
    held_sum = 16'h8000;
    held_avg = 16'hE000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {14'd0, sum_out_valid, avg_out_valid}, 16'h0003);
      check("bp_sum_stable", sum_out_data, held_sum);
      check("bp_avg_stable", avg_out_data, held_avg);
      check("bp_in_ready", {14'd0, sum_in_ready, avg_in_ready}, 16'h0000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("idle_after_bp");

    @(posedge clk);
    #1;
    expect_window(16'h000A, 16'h0002);
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    send(16'h0004);
    wait_idle("idle_after_1234");

    // Input gaps: same result, busy held throughout the window.
    @(posedge clk);
    #1;
    expect_window(16'h00A0, 16'h0028);
    for (int b = 0; b < 4; b++) begin
      send(16'h0010 * 16'(b + 1));
      for (int g = 0; g <= b % 3; g++) begin
        if (b == 3) break;
        @(negedge clk);
        check("gap_busy", {14'd0, sum_busy, avg_busy}, 16'h0003);
        @(posedge clk);
        #1;
      end
    end
    wait_idle("idle_after_gaps");

    // Reset mid-window discards the partial sum.
    @(posedge clk);
    #1;
    send(16'h0100);
    send(16'h0100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    expect_window(16'h0004, 16'h0001);
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    wait_idle("idle_after_reset_window");

    repeat (2) @(negedge clk);
    check("sum_queue_drained", 16'(exp_sum_q.size()), 16'd0);
    check("avg_queue_drained", 16'(exp_avg_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
